instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 87 ++++++++
 rtl/instr_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT = 2;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } fetch_state_t;

    // One fetch-queue entry: instruction word tagged with its byte address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with flush, occupancy count and flags.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     din,
    input  logic             pop,
    output fetch_entry_t     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags and head-of-queue outputs.
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        count = count_q;
        dout  = mem_q[rd_ptr_q];
    end

    // Next-state: flush wins over push/pop; push into a full queue only alongside a pop.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_c  = pop & ~flush & ~empty;
        do_push_c = push & ~flush & (~full | do_pop_c);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, memory requests, redirect/halt/error handling.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_ready,
    output logic            misalign_err
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic             q_flush_c, q_push_c, q_pop_c;
    logic [CNT_W-1:0] q_count;
    logic             q_full, q_empty;
    fetch_entry_t     q_din, q_dout;
    logic [OCC_W-1:0] occ_c;
    logic             bad_redirect_c;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (q_flush_c),
        .push  (q_push_c),
        .din   (q_din),
        .pop   (q_pop_c),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // FSM next state: misaligned redirect is terminal until reset; halt toggles RUN/HALTED.
    always_comb begin
        state_d        = state_q;
        bad_redirect_c = redirect_valid & ~is_word_aligned(redirect_pc);
        case (state_q)
            RUN: begin
                if (bad_redirect_c)   state_d = ERROR;
                else if (halt)        state_d = HALTED;
            end
            HALTED: begin
                if (bad_redirect_c)   state_d = ERROR;
                else if (!halt)       state_d = RUN;
            end
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // Datapath and outputs: request credit, queue control, PC update.
    always_comb begin
        imem_addr     = pc_q;
        misalign_err  = (state_q == ERROR);
        fetch_valid   = ~q_empty & ~redirect_valid & (state_q != ERROR);
        fetch_pc      = q_dout.pc;
        fetch_instr   = q_dout.instr;
        q_pop_c       = fetch_valid & fetch_ready;
        q_flush_c     = redirect_valid | (state_q == ERROR);
        // Occupancy counts the slot reserved by the response already on its way back.
        occ_c         = OCC_W'(q_count) + OCC_W'(inflight_q) - OCC_W'(q_pop_c);
        imem_req      = ~rst & (state_q == RUN) & ~halt & ~redirect_valid
                        & (occ_c < OCC_W'(FQ_DEPTH));
        q_push_c      = inflight_q & ~q_flush_c & (~q_full | q_pop_c);
        q_din.pc      = inflight_pc_q;
        q_din.instr   = imem_rdata;
        inflight_d    = imem_req;
        inflight_pc_d = imem_req ? pc_q : inflight_pc_q;
        pc_d          = pc_q;
        if ((state_q != ERROR) && redirect_valid && is_word_aligned(redirect_pc)) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // State registers; reset drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl (queue depth 3).
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word k holds k; data returns one cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? {2'b00, imem_addr[31:2]} : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(imem_req), 32'(req));
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic exp_fetch(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
        chk({tag, "_fv"}, 32'(fetch_valid), 32'(v));
        if (v) begin
            chk({tag, "_pc"}, fetch_pc, pc);
            chk({tag, "_instr"}, fetch_instr, instr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        fetch_ready    = rdy;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        fetch_ready    = 1'b1;

        // Reset state
        step(); step();
        exp_req("rst", 1'b0, 32'h0);
        exp_fetch("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_err", 32'(misalign_err), 32'h0);

        // Free-running fetch from reset: one request per cycle, data after a 2-cycle fill
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) rst = 1'b0;
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            exp_req($sformatf("A%0d", k), 1'b1, 32'(4 * k));
            if (k >= 2) exp_fetch($sformatf("A%0d", k), 1'b1, 32'(4 * (k - 2)), 32'(k - 2));
            else        exp_fetch($sformatf("A%0d", k), 1'b0, 32'h0, 32'h0);
        end

        // Back-pressure: queue fills to 3 entries (16,20,24), then requests stop
        step(); drive(1'b0, 32'h0, 1'b0, 1'b0);
        exp_req("B0", 1'b1, 32'd24);
        exp_fetch("B0", 1'b1, 32'd16, 32'd4);
        for (int k = 1; k < 5; k++) begin
            step(); drive(1'b0, 32'h0, 1'b0, 1'b0);
            exp_req($sformatf("B%0d", k), 1'b0, 32'h0);
            exp_fetch($sformatf("B%0d", k), 1'b1, 32'd16, 32'd4);
        end
        // Ready returns: drain in order with no loss or duplicate
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("E0", 1'b1, 32'd28);  exp_fetch("E0", 1'b1, 32'd16, 32'd4);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("E1", 1'b1, 32'd32);  exp_fetch("E1", 1'b1, 32'd20, 32'd5);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("E2", 1'b1, 32'd36);  exp_fetch("E2", 1'b1, 32'd24, 32'd6);

        // Aligned redirect with 2 queued + 1 in flight, fetch_ready high
        step(); drive(1'b1, 32'h40, 1'b0, 1'b1);
        exp_req("R0", 1'b0, 32'h0);   exp_fetch("R0", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("R1", 1'b1, 32'h40);  exp_fetch("R1", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("R2", 1'b1, 32'h44);  exp_fetch("R2", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("R3", 1'b1, 32'h48);  exp_fetch("R3", 1'b1, 32'h40, 32'h10);

        // Halt for 3 cycles with 0x48 in flight: it is still delivered, no new requests
        step(); drive(1'b0, 32'h0, 1'b1, 1'b1);
        exp_req("H0", 1'b0, 32'h0);   exp_fetch("H0", 1'b1, 32'h44, 32'h11);
        step(); drive(1'b0, 32'h0, 1'b1, 1'b1);
        exp_req("H1", 1'b0, 32'h0);   exp_fetch("H1", 1'b1, 32'h48, 32'h12);
        step(); drive(1'b0, 32'h0, 1'b1, 1'b1);
        exp_req("H2", 1'b0, 32'h0);   exp_fetch("H2", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("H3", 1'b0, 32'h0);   exp_fetch("H3", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("H4", 1'b1, 32'h4C);  exp_fetch("H4", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("H5", 1'b1, 32'h50);  exp_fetch("H5", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("H6", 1'b1, 32'h54);  exp_fetch("H6", 1'b1, 32'h4C, 32'h13);

        // PC wrap at the top of the address space
        step(); drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        exp_req("W0", 1'b0, 32'h0);           exp_fetch("W0", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("W1", 1'b1, 32'hFFFF_FFF8);   exp_fetch("W1", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("W2", 1'b1, 32'hFFFF_FFFC);   exp_fetch("W2", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("W3", 1'b1, 32'h0000_0000);   exp_fetch("W3", 1'b1, 32'hFFFF_FFF8, 32'h3FFF_FFFE);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("W4", 1'b1, 32'h0000_0004);   exp_fetch("W4", 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("W5", 1'b1, 32'h0000_0008);   exp_fetch("W5", 1'b1, 32'h0000_0000, 32'h0);

        // Misaligned redirect: sticky error; a later aligned redirect does not clear it
        step(); drive(1'b1, 32'h42, 1'b0, 1'b1);
        exp_req("M0", 1'b0, 32'h0);   exp_fetch("M0", 1'b0, 32'h0, 32'h0);
        chk("M0_err", 32'(misalign_err), 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("M1", 1'b0, 32'h0);   exp_fetch("M1", 1'b0, 32'h0, 32'h0);
        chk("M1_err", 32'(misalign_err), 32'h1);
        step(); drive(1'b1, 32'h80, 1'b0, 1'b1);
        exp_req("M2", 1'b0, 32'h0);   exp_fetch("M2", 1'b0, 32'h0, 32'h0);
        chk("M2_err", 32'(misalign_err), 32'h1);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("M3", 1'b0, 32'h0);   exp_fetch("M3", 1'b0, 32'h0, 32'h0);
        chk("M3_err", 32'(misalign_err), 32'h1);

        // Reset clears the error; fetch restarts at RESET_PC
        step(); rst = 1'b1; drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("X0", 1'b0, 32'h0);   exp_fetch("X0", 1'b0, 32'h0, 32'h0);
        chk("X0_err", 32'(misalign_err), 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("X1", 1'b0, 32'h0);
        step(); rst = 1'b0; drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Y0", 1'b1, 32'h0);   exp_fetch("Y0", 1'b0, 32'h0, 32'h0);
        chk("Y0_err", 32'(misalign_err), 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Y1", 1'b1, 32'h4);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Y2", 1'b1, 32'h8);   exp_fetch("Y2", 1'b1, 32'h0, 32'h0);

        // Reset mid-stream with a response in flight: it must not reappear
        step(); rst = 1'b1; drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Y3", 1'b0, 32'h0);   exp_fetch("Y3", 1'b0, 32'h0, 32'h0);
        step(); rst = 1'b0; drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Z0", 1'b1, 32'h0);   exp_fetch("Z0", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Z1", 1'b1, 32'h4);   exp_fetch("Z1", 1'b0, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Z2", 1'b1, 32'h8);   exp_fetch("Z2", 1'b1, 32'h0, 32'h0);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_req("Z3", 1'b1, 32'hC);   exp_fetch("Z3", 1'b1, 32'h4, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
